// File: rtl/sequence_player_pkg.sv
// seq_pkg: shared types and width helpers for the sequence_player block.
//   state_t    : playback FSM state encoding
//   cnt_width  : counter/index width, never below 1 bit
//   len_width  : width needed to hold a count of 0..n
package seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int len_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sequence_player_if.sv
// sequence_player_if: playback request/response bundle.
//   master : sequence generator side (drives start, abort, sequence_bits, length)
//   slave  : sequence_player side (drives direction_arrow, arrow_valid,
//            step_index, busy, stop)
// sequence_bits carries the packed steps, step 0 in the most significant DIR_W
// bits ("sequence" itself is a reserved word).
interface sequence_player_if #(
  parameter int DIR_W   = 2,
  parameter int SEQ_LEN = 4
) ();
  localparam int SEQ_W = SEQ_LEN * DIR_W;
  localparam int LEN_W = seq_pkg::len_width(SEQ_LEN);
  localparam int IDX_W = seq_pkg::cnt_width(SEQ_LEN);

  logic             start;
  logic             abort;
  logic [SEQ_W-1:0] sequence_bits;
  logic [LEN_W-1:0] length;
  logic [DIR_W-1:0] direction_arrow;
  logic             arrow_valid;
  logic [IDX_W-1:0] step_index;
  logic             busy;
  logic             stop;

  modport master (
    output start, abort, sequence_bits, length,
    input  direction_arrow, arrow_valid, step_index, busy, stop
  );

  modport slave (
    input  start, abort, sequence_bits, length,
    output direction_arrow, arrow_valid, step_index, busy, stop
  );
endinterface

// File: rtl/sequence_player_tick_divider.sv
// tick_divider: interval timer, DIV enabled clocks per terminal count.
//   clock, resetn : clock, async active-low reset
//   clear         : reload to the start of an interval
//   enable        : count this cycle
//   tc            : high on the last enabled cycle of each interval
// Counts down from DIV-1; the reload value is the "cleared" state.
module tick_divider
  import seq_pkg::*;
#(
  parameter int DIV = 8
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic tc
);
  localparam int            CW   = cnt_width(DIV);
  localparam logic [CW-1:0] LOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= LOAD;
    end else if (clear || (enable && cnt_q == '0)) begin
      cnt_q <= LOAD;
    end else if (enable) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign tc = enable && (cnt_q == '0);
endmodule

// File: rtl/sequence_player.sv
// sequence_player: plays a latched sequence of direction codes, one step per
// TICK_DIV clocks, then pulses stop for one cycle.
//   clock, resetn : clock, async active-low reset
//   bus (slave)   : start/abort/sequence_bits/length in;
//                   direction_arrow/arrow_valid/step_index/busy/stop out
// Build option SEQ_PLAYER_GAP_EN: inserts GAP_DIV blank clocks between steps.
//
// state  | meaning
// S_IDLE | waiting for start
// S_SHOW | presenting step step_q for TICK_DIV clocks
// S_GAP  | blank between steps, step_q already points at the next step
// S_DONE | single cycle, produces the stop pulse
//
// Outputs are registered from the current state, so they trail the state by
// one clock; abort zeroes them at the same edge it returns the FSM to idle.
module sequence_player
  import seq_pkg::*;
#(
  parameter int DIR_W    = 2,
  parameter int SEQ_LEN  = 4,
  parameter int TICK_DIV = 8,
  parameter int GAP_DIV  = 4
) (
  input logic              clock,
  input logic              resetn,
  sequence_player_if.slave bus
);
  localparam int               SEQ_W   = SEQ_LEN * DIR_W;
  localparam int               LEN_W   = len_width(SEQ_LEN);
  localparam int               IDX_W   = cnt_width(SEQ_LEN);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(SEQ_LEN);

  state_t           state_q, state_d;
  logic [SEQ_W-1:0] seq_q, seq_shifted;
  logic [LEN_W-1:0] len_q, len_eff;
  logic [IDX_W-1:0] step_q, step_d;
  logic             load;
  logic             show_tc, gap_tc, last_step;
  logic             in_show, in_gap;

  logic [DIR_W-1:0] arrow_d, arrow_q;
  logic [IDX_W-1:0] idx_d, idx_q;
  logic             valid_d, valid_q, busy_d, busy_q, stop_d, stop_q;

  assign in_show = (state_q == S_SHOW);
  assign in_gap  = (state_q == S_GAP);

  // Timers are held in reload outside their own state, so each visit starts
  // a full interval.
  tick_divider #(.DIV(TICK_DIV)) u_show_div (
    .clock (clock),
    .resetn(resetn),
    .clear (!in_show),
    .enable(in_show),
    .tc    (show_tc)
  );

  tick_divider #(.DIV(GAP_DIV)) u_gap_div (
    .clock (clock),
    .resetn(resetn),
    .clear (!in_gap),
    .enable(in_gap),
    .tc    (gap_tc)
  );

  assign len_eff     = (bus.length > MAX_LEN) ? MAX_LEN : bus.length;
  assign last_step   = ((LEN_W'(step_q) + LEN_W'(1)) == len_q);
  assign seq_shifted = seq_q << (DIR_W * int'(step_q));

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    load    = 1'b0;
    arrow_d = '0;
    idx_d   = '0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    stop_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          load    = 1'b1;
          step_d  = '0;
          state_d = (len_eff == '0) ? S_DONE : S_SHOW;
        end
      end
      S_SHOW: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
        idx_d   = step_q;
        arrow_d = seq_shifted[SEQ_W-1 -: DIR_W];
        if (show_tc) begin
          if (last_step) begin
            state_d = S_DONE;
          end else begin
            step_d = step_q + IDX_W'(1);
`ifdef SEQ_PLAYER_GAP_EN
            state_d = S_GAP;
`else
            state_d = S_SHOW;
`endif
          end
        end
      end
      S_GAP: begin
        busy_d = 1'b1;
        idx_d  = step_q;
        if (gap_tc) state_d = S_SHOW;
      end
      S_DONE: begin
        stop_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      arrow_d = '0;
      idx_d   = '0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      stop_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      step_q  <= '0;
      seq_q   <= '0;
      len_q   <= '0;
      arrow_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      step_q <= step_d;
      if (load) begin
        seq_q <= bus.sequence_bits;
        len_q <= len_eff;
      end
      arrow_q <= arrow_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      stop_q  <= stop_d;
    end
  end

  assign bus.direction_arrow = arrow_q;
  assign bus.step_index      = idx_q;
  assign bus.arrow_valid     = valid_q;
  assign bus.busy            = busy_q;
  assign bus.stop            = stop_q;
endmodule
